// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR bit scheduler.
// Holds the scheduler state encoding and the LFSR geometry constants.
// Combinational helpers only; no timing or flow control of its own.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int LFSR_WIDTH      = 8;
  localparam int LFSR_PERIOD_LEN = 255;

  // Saturating increment for the period counter.
  function automatic logic [LFSR_WIDTH-1:0] sat_inc(input logic [LFSR_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lfsr_sched_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index with highest priority this cycle (must be < NREQ)
//   gnt  - one-hot winner (all zero when no request)
//   any  - at least one request is pending
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  localparam logic [PTRW:0] NREQ_V = (PTRW+1)'(NREQ);

  logic [PTRW:0] pos;
  logic          found;

  // Walk the requesters starting at ptr. pos carries one extra bit so the
  // sum ptr+k never overflows before the modulo fold; ptr < NREQ means a
  // single subtraction is enough to bring it back into range.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (PTRW+1)'(k);
      if (pos >= NREQ_V) begin
        pos = pos - NREQ_V;
      end
      if (!found && req[pos[PTRW-1:0]]) begin
        gnt[pos[PTRW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one 8-bit LFSR bit source among NREQ requesters.
// Latency: REQ in cycle n -> GNT and first BIT_VALID in cycle n+1; NBITS bits per grant, 2-cycle gap.
// Backpressure: a grantee holds REQ until DONE; dropping REQ mid-grant aborts it with no DONE.
//
// Optional build macro LFSR_SELFTEST_EN: the LFSR free-runs while idle and a
// gap counter checks that LFSR_PERIOD recurs every 255 enabled cycles,
// raising the sticky PERIOD_ERR otherwise. Without it PERIOD_ERR is 0.
//
// Ports:
//   CLK         - system clock, rising edge
//   RESET       - asynchronous active-low reset
//   REQ         - per-requester request level, held until DONE
//   LFSR_BIT    - LFSR output bit (LSB of its state)
//   LFSR_PERIOD - high while the LFSR state is 0xFF
//   LFSR_EN     - LFSR advance enable
//   GNT         - registered one-hot grant
//   BIT_OUT     - random bit for the current grantee
//   BIT_VALID   - BIT_OUT is valid this cycle
//   DONE        - one-cycle completion pulse to the grantee
//   PERIOD_CNT  - saturating count of full LFSR periods seen while enabled
//   PERIOD_ERR  - sticky period self-test error
module lfsr_sched
  import lfsr_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       REQ,
  input  logic                  LFSR_BIT,
  input  logic                  LFSR_PERIOD,
  output logic                  LFSR_EN,
  output logic [NREQ-1:0]       GNT,
  output logic                  BIT_OUT,
  output logic                  BIT_VALID,
  output logic [NREQ-1:0]       DONE,
  output logic [LFSR_WIDTH-1:0] PERIOD_CNT,
  output logic                  PERIOD_ERR
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef LFSR_SELFTEST_EN
  localparam logic IDLE_EN = 1'b1;
`else
  localparam logic IDLE_EN = 1'b0;
`endif

  state_t                state;
  logic [PTRW-1:0]       rr_ptr;
  logic [7:0]            bit_cnt;
  logic [NREQ-1:0]       pick_gnt;
  logic                  pick_any;
  logic [PTRW-1:0]       nxt_ptr;
  logic                  grantee_req;

  rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .req (REQ),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // Pointer moves to the slot after the current grantee, whether the grant
  // completed or was aborted, so an aborting requester cannot hog priority.
  always_comb begin
    nxt_ptr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GNT[i]) begin
        nxt_ptr = (i == NREQ - 1) ? '0 : PTRW'(i + 1);
      end
    end
  end

  assign grantee_req = |(REQ & GNT);

  // The LFSR shifts on the same edge that consumes the bit, so the bit
  // forwarded here is the value before that shift.
  assign BIT_OUT = BIT_VALID & LFSR_BIT;

  // Scheduler FSM. All outputs are registered alongside the state so an
  // asynchronous reset drops every one of them at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      GNT       <= '0;
      DONE      <= '0;
      BIT_VALID <= 1'b0;
      LFSR_EN   <= 1'b0;
      rr_ptr    <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= '0;
          if (pick_any) begin
            GNT       <= pick_gnt;
            bit_cnt   <= 8'(NBITS);
            BIT_VALID <= 1'b1;
            LFSR_EN   <= 1'b1;
            state     <= SHIFT;
          end else begin
            LFSR_EN <= IDLE_EN;
          end
        end

        SHIFT: begin
          bit_cnt <= bit_cnt - 8'd1;
          if (!grantee_req) begin
            // Grantee gave up: drop the grant silently, no DONE.
            state     <= IDLE;
            GNT       <= '0;
            BIT_VALID <= 1'b0;
            LFSR_EN   <= IDLE_EN;
            rr_ptr    <= nxt_ptr;
          end else if (bit_cnt == 8'd1) begin
            state     <= RELEASE;
            BIT_VALID <= 1'b0;
            LFSR_EN   <= 1'b0;
            DONE      <= GNT;
          end
        end

        RELEASE: begin
          state   <= IDLE;
          GNT     <= '0;
          DONE    <= '0;
          rr_ptr  <= nxt_ptr;
          LFSR_EN <= IDLE_EN;
        end

        default: begin
          state     <= IDLE;
          GNT       <= '0;
          DONE      <= '0;
          BIT_VALID <= 1'b0;
          LFSR_EN   <= 1'b0;
        end
      endcase
    end
  end

  // A full period is counted on the edge that shifts the LFSR out of 0xFF.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PERIOD_CNT <= '0;
    end else if (LFSR_EN && LFSR_PERIOD) begin
      PERIOD_CNT <= sat_inc(PERIOD_CNT);
    end
  end

`ifdef LFSR_SELFTEST_EN
  // gap_cnt counts enabled edges since the last LFSR_PERIOD edge; the edge
  // carrying the next assertion makes the gap gap_cnt+1. It saturates so a
  // missing assertion cannot wrap around into a false pass.
  logic [7:0] gap_cnt;
  logic       armed;
  logic       err_q;
  logic [8:0] gap;

  assign gap = {1'b0, gap_cnt} + 9'd1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      gap_cnt <= '0;
      armed   <= 1'b0;
      err_q   <= 1'b0;
    end else if (LFSR_EN) begin
      if (LFSR_PERIOD) begin
        if (armed && (gap != 9'(LFSR_PERIOD_LEN))) begin
          err_q <= 1'b1;
        end
        armed   <= 1'b1;
        gap_cnt <= '0;
      end else if (gap_cnt != 8'hFF) begin
        gap_cnt <= gap_cnt + 8'd1;
      end
    end
  end

  assign PERIOD_ERR = err_q;
`else
  assign PERIOD_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_sched.sv
// Directed bench for lfsr_sched with NREQ=4, NBITS=8.
// Provides a behavioural LFSR8 (left shift, taps 0x95, seed 0x01) as the bit source.
// Each scenario task drives stimulus and checks outputs 1 time unit after the rising edge.
module tb_lfsr_sched;

  logic       CLK;
  logic       RESET;
  logic [3:0] REQ;
  logic       LFSR_BIT;
  logic       LFSR_PERIOD;
  logic       LFSR_EN;
  logic [3:0] GNT;
  logic       BIT_OUT;
  logic       BIT_VALID;
  logic [3:0] DONE;
  logic [7:0] PERIOD_CNT;
  logic       PERIOD_ERR;

  logic [7:0] env_lfsr;
  logic       force_period;

  int errors = 0;
  int checks = 0;

  lfsr_sched #(.NREQ(4), .NBITS(8)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .REQ         (REQ),
    .LFSR_BIT    (LFSR_BIT),
    .LFSR_PERIOD (LFSR_PERIOD),
    .LFSR_EN     (LFSR_EN),
    .GNT         (GNT),
    .BIT_OUT     (BIT_OUT),
    .BIT_VALID   (BIT_VALID),
    .DONE        (DONE),
    .PERIOD_CNT  (PERIOD_CNT),
    .PERIOD_ERR  (PERIOD_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'h95)};
  endfunction

  // External LFSR8 instance, reset together with the scheduler.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) env_lfsr <= 8'h01;
    else if (LFSR_EN) env_lfsr <= lfsr_next(env_lfsr);
  end

  assign LFSR_BIT    = env_lfsr[0];
  assign LFSR_PERIOD = (env_lfsr == 8'hFF) || force_period;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut;
    RESET = 1'b0;
    REQ = 4'b0000;
    force_period = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    REQ = 4'b0000;
    force_period = 1'b0;
    tick;
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", GNT); end
    checks++; if (DONE !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", DONE); end
    checks++; if (BIT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", BIT_VALID); end
    checks++; if (LFSR_EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", LFSR_EN); end
    checks++; if (PERIOD_CNT !== 8'd0) begin errors++; $display("FAIL reset_pcnt: got %0d want 0", PERIOD_CNT); end
    checks++; if (PERIOD_ERR !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", PERIOD_ERR); end
    tick;
    RESET = 1'b1;
  endtask

  task automatic test_single;
    int bits;
    reset_dut;
    REQ = 4'b0001;
    checks++; if (GNT !== 4'b0000) begin errors++; $display("FAIL single_pre: got %b want 0000", GNT); end
    tick;
    checks++; if (GNT !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", GNT); end
    bits = 0;
    repeat (8) begin
      if (BIT_VALID === 1'b1 && LFSR_EN === 1'b1 && GNT === 4'b0001 && DONE === 4'b0000) bits++;
      tick;
    end
    checks++; if (bits != 8) begin errors++; $display("FAIL single_bits: got %0d want 8", bits); end
    checks++; if (DONE !== 4'b0001 || BIT_VALID !== 1'b0 || LFSR_EN !== 1'b0) begin
      errors++; $display("FAIL single_release: done=%b valid=%b en=%b want 0001/0/0", DONE, BIT_VALID, LFSR_EN);
    end
    tick;
    checks++; if (GNT !== 4'b0000 || DONE !== 4'b0000) begin
      errors++; $display("FAIL single_gap: gnt=%b done=%b want 0000/0000", GNT, DONE);
    end
    tick;
    checks++; if (GNT !== 4'b0001 || BIT_VALID !== 1'b1) begin
      errors++; $display("FAIL single_regrant: gnt=%b valid=%b want 0001/1", GNT, BIT_VALID);
    end
    REQ = 4'b0000;
    tick;
    tick;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    int bits;
    reset_dut;
    REQ = 4'b1111;
    tick;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      checks++; if (GNT !== exp) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", g, GNT, exp); end
      bits = 0;
      repeat (8) begin
        if (BIT_VALID === 1'b1 && GNT === exp) bits++;
        tick;
      end
      checks++; if (bits != 8) begin errors++; $display("FAIL rr_bits%0d: got %0d want 8", g, bits); end
      checks++; if (DONE !== exp) begin errors++; $display("FAIL rr_done%0d: got %b want %b", g, DONE, exp); end
      tick;
      tick;
    end
    REQ = 4'b0000;
    tick;
    tick;
  endtask

  task automatic test_bit_seq;
    logic [7:0] ref_s;
    logic [3:0] first4;
    logic       adv;
    int nvalid, nbad, pcnt;
    reset_dut;
    ref_s = 8'h01;
    first4 = 4'b0000;
    nvalid = 0;
    nbad = 0;
    pcnt = 0;
    REQ = 4'b0001;
    for (int cyc = 0; cyc < 600 && nvalid < 256; cyc++) begin
      if (BIT_VALID === 1'b1) begin
        if (BIT_OUT !== ref_s[0]) nbad++;
        if (nvalid < 4) first4 = {BIT_OUT, first4[3:1]};
        nvalid++;
      end
`ifdef LFSR_SELFTEST_EN
      adv = LFSR_EN;
`else
      adv = BIT_VALID;
`endif
      if (adv === 1'b1) begin
        if (ref_s == 8'hFF) pcnt++;
        ref_s = lfsr_next(ref_s);
      end
      tick;
    end
    checks++; if (nvalid != 256) begin errors++; $display("FAIL seq_timeout: got %0d bits want 256", nvalid); end
    checks++; if (nbad != 0) begin errors++; $display("FAIL seq_bits: got %0d wrong bits want 0", nbad); end
    checks++; if (PERIOD_CNT !== 8'(pcnt)) begin errors++; $display("FAIL seq_pcnt: got %0d want %0d", PERIOD_CNT, pcnt); end
`ifndef LFSR_SELFTEST_EN
    checks++; if (first4 !== 4'b0111) begin errors++; $display("FAIL seq_first4: got %b want 0111", first4); end
`endif
    REQ = 4'b0000;
    tick;
    tick;
  endtask

  task automatic test_abort;
    reset_dut;
    REQ = 4'b0100;
    tick;
    checks++; if (GNT !== 4'b0100) begin errors++; $display("FAIL abort_gnt: got %b want 0100", GNT); end
    tick;
    tick;
    checks++; if (BIT_VALID !== 1'b1) begin errors++; $display("FAIL abort_bit3: got %b want 1", BIT_VALID); end
    REQ = 4'b0000;
    tick;
    checks++; if (GNT !== 4'b0000 || BIT_VALID !== 1'b0 || DONE !== 4'b0000) begin
      errors++; $display("FAIL abort_clear: gnt=%b valid=%b done=%b want 0000/0/0000", GNT, BIT_VALID, DONE);
    end
    REQ = 4'b1111;
    tick;
    checks++; if (GNT !== 4'b1000) begin errors++; $display("FAIL abort_ptr: got %b want 1000", GNT); end
    REQ = 4'b0000;
    tick;
    tick;
  endtask

  task automatic test_reset_mid;
    reset_dut;
    REQ = 4'b0001;
    tick;
    repeat (4) tick;
    checks++; if (BIT_VALID !== 1'b1 || GNT !== 4'b0001) begin
      errors++; $display("FAIL mid_shift: valid=%b gnt=%b want 1/0001", BIT_VALID, GNT);
    end
    #2;
    RESET = 1'b0;
    #1;
    checks++; if (GNT !== 4'b0000 || BIT_VALID !== 1'b0 || LFSR_EN !== 1'b0 || DONE !== 4'b0000) begin
      errors++; $display("FAIL mid_async: gnt=%b valid=%b en=%b done=%b want all 0", GNT, BIT_VALID, LFSR_EN, DONE);
    end
    REQ = 4'b0000;
    tick;
    RESET = 1'b1;
    tick;
    tick;
    checks++; if (GNT !== 4'b0000 || DONE !== 4'b0000) begin
      errors++; $display("FAIL mid_idle: gnt=%b done=%b want 0000/0000", GNT, DONE);
    end
    REQ = 4'b0001;
    tick;
    checks++; if (GNT !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b want 0001", GNT); end
    REQ = 4'b0000;
    tick;
    tick;
  endtask

`ifdef LFSR_SELFTEST_EN
  task automatic test_selftest;
    int en_low;
    int guard;
    reset_dut;
    tick;
    en_low = 0;
    repeat (600) begin
      if (LFSR_EN !== 1'b1) en_low++;
      tick;
    end
    checks++; if (en_low != 0) begin errors++; $display("FAIL st_idle_en: got %0d idle cycles without enable want 0", en_low); end
    checks++; if (PERIOD_ERR !== 1'b0) begin errors++; $display("FAIL st_clean: got %b want 0", PERIOD_ERR); end
    guard = 0;
    while (env_lfsr == 8'hFF && guard < 4) begin
      tick;
      guard++;
    end
    force_period = 1'b1;
    tick;
    force_period = 1'b0;
    tick;
    checks++; if (PERIOD_ERR !== 1'b1) begin errors++; $display("FAIL st_err_set: got %b want 1", PERIOD_ERR); end
    repeat (300) tick;
    checks++; if (PERIOD_ERR !== 1'b1) begin errors++; $display("FAIL st_err_sticky: got %b want 1", PERIOD_ERR); end
    reset_dut;
    checks++; if (PERIOD_ERR !== 1'b0) begin errors++; $display("FAIL st_err_reset: got %b want 0", PERIOD_ERR); end
  endtask
`else
  task automatic test_selftest;
    int en_high;
    reset_dut;
    en_high = 0;
    repeat (20) begin
      if (LFSR_EN !== 1'b0) en_high++;
      tick;
    end
    checks++; if (en_high != 0) begin errors++; $display("FAIL st_idle_en: got %0d idle cycles with enable want 0", en_high); end
    force_period = 1'b1;
    repeat (3) tick;
    force_period = 1'b0;
    tick;
    checks++; if (PERIOD_ERR !== 1'b0) begin errors++; $display("FAIL st_err_off: got %b want 0", PERIOD_ERR); end
    checks++; if (PERIOD_CNT !== 8'd0) begin errors++; $display("FAIL st_pcnt_off: got %0d want 0", PERIOD_CNT); end
  endtask
`endif

  initial begin
    RESET = 1'b0;
    REQ = 4'b0000;
    force_period = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_bit_seq;
    test_abort;
    test_reset_mid;
    test_selftest;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
